mem1: RTL
=========

MEM1 -- requirements
Module: mem1

Interface
REQ-001 Parameter EX2MEM1_WD, default 117, width of the incoming EX-to-MEM1 bus.
REQ-002 Parameter MEM12WB_WD, default 105, width of the outgoing MEM1-to-WB bus.
REQ-003 Parameter BYPASS_WD, default 38, width of the forwarding bus.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 stall  input  6  pipeline stall vector; stall[4] = MEM1 stalled, stall[5] = downstream stalled.
REQ-007 ex2mem1_bus  input  EX2MEM1_WD  fields MSB..LSB: lsu_op[7:0], data_ram_sel[3:0], sel_rf_res[2:0], rf_we, rf_waddr[4:0], ex_result[31:0], pc[31:0], inst[31:0].
REQ-008 data_sram_rdata  input  32  data SRAM read data, valid one cycle after the access is issued by EX.
REQ-009 mem12wb_bus  output  MEM12WB_WD  fields MSB..LSB: sel_rf_res[2:0], rf_we, rf_waddr[4:0], mem1_result[31:0], pc[31:0], inst[31:0].
REQ-010 mem12rf_bus  output  BYPASS_WD  {rf_we, rf_waddr[4:0], mem1_result[31:0]} for forwarding to ID.
REQ-011 mem1_is_load  output  1  high when the held instruction is a load (lsu_op[4:0] nonzero); used by the hazard unit.

Function
REQ-012 lsu_op one-hot: [0] lb, [1] lbu, [2] lh, [3] lhu, [4] lw, [5] sb, [6] sh, [7] sw; all-zero means a non-memory instruction.
REQ-013 Pipeline register update: if stall[4] and not stall[5], load all-zero (bubble); else if not stall[4], capture ex2mem1_bus; else hold.
REQ-014 Rdata hold buffer: 32-bit hold_data plus a held flag.
REQ-015 The held flag SHALL set, and hold_data SHALL latch data_sram_rdata, on the first clock edge at which stall[4] is high while held is low.
REQ-016 The held flag SHALL clear on any edge at which the pipeline register loads new content (capture or bubble).
REQ-017 Effective read data is hold_data when held is 1, else data_sram_rdata.
REQ-018 Byte lane select from data_ram_sel: lb/lbu use the one-hot lane 0001/0010/0100/1000 -> byte 0/1/2/3; lh/lhu use 0011 -> low half, 1100 -> high half; lw uses 1111.
REQ-019 lb/lh sign-extend the selected byte/half to 32 bits; lbu/lhu zero-extend; lw passes all 32 bits unchanged.
REQ-020 An invalid lane pattern for a load SHALL yield load data 0.
REQ-021 mem1_result = load data when sel_rf_res[1] is 1, else the registered ex_result.
REQ-022 Stores and non-memory instructions pass ex_result unchanged; a store's rf_we passes through as registered.
REQ-023 All outputs are combinational from the pipeline register, hold buffer and data_sram_rdata; zero added latency beyond the stage register.
REQ-024 Bubble content is all-zero, so rf_we=0 and mem1_is_load=0.

Reset
REQ-025 While rst_n=0 at a clock edge: pipeline register <= 0, hold_data <= 0, held <= 0.
REQ-026 After reset, mem12wb_bus has all fields 0 except mem1_result, which equals data_sram_rdata-independent 0 because sel_rf_res=0.
REQ-027 After reset, mem12rf_bus = 0 and mem1_is_load = 0.
REQ-028 Reset asserted mid-stall SHALL discard the held data and clear held in the same edge.

Verification
REQ-029 lb, data_ram_sel=0100, rdata=0x12AB3456, sel_rf_res[1]=1 -> mem1_result=0xFFFFFFAB, rf_we forwarded on mem12rf_bus.
REQ-030 lhu, data_ram_sel=1100, rdata=0x8001FFFF -> mem1_result=0x00008001; the same access as lh -> 0xFFFF8001.
REQ-031 lw, rdata=0xDEADBEEF, then stall[4]=stall[5]=1 for 3 cycles while rdata changes to 0x11111111 -> mem1_result stays 0xDEADBEEF for all 3 cycles; held clears when stall drops.
REQ-032 stall[4]=1 with stall[5]=0 -> next cycle mem12wb_bus = 0 (bubble) and mem1_is_load = 0.
REQ-033 ALU op, ex_result=0x00000042, sel_rf_res=001, rf_waddr=5 -> mem1_result=0x42 and mem12rf_bus={1,5,0x42}, independent of rdata.
REQ-034 rst_n=0 during a held load -> held=0, outputs 0 next cycle; the first load after reset uses live rdata.

Source files
------------

// File: rtl/mem1.sv
// mem1: MEM1 pipeline stage with load data extraction, stall hold buffer and forwarding bus
module mem1 #(
    parameter int EX2MEM1_WD = 117,
    parameter int MEM12WB_WD = 105,
    parameter int BYPASS_WD  = 38
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            stall,
    input  logic [EX2MEM1_WD-1:0] ex2mem1_bus,
    input  logic [31:0]           data_sram_rdata,
    output logic [MEM12WB_WD-1:0] mem12wb_bus,
    output logic [BYPASS_WD-1:0]  mem12rf_bus,
    output logic                  mem1_is_load
);
    logic [EX2MEM1_WD-1:0] pipe_q, pipe_d;
    logic [31:0]           hold_q, hold_d;
    logic                  held_q, held_d;
    logic [7:0]            lsu_op;
    logic [3:0]            sel;
    logic [31:0]           ex_result, rdata, load_data, result;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic                  ok_b, ok_h;
    logic                  unused_store_ops;

    assign lsu_op    = pipe_q[116:109];
    assign sel       = pipe_q[108:105];
    assign ex_result = pipe_q[95:64];
    assign unused_store_ops = ^lsu_op[7:5];

    // Next state: capture or bubble clears the hold buffer; the first held-stall edge freezes read data
    always_comb begin
        pipe_d = pipe_q;
        hold_d = hold_q;
        held_d = held_q;
        if (!stall[4]) begin
            pipe_d = ex2mem1_bus;
            held_d = 1'b0;
        end else if (!stall[5]) begin
            pipe_d = '0;
            held_d = 1'b0;
        end else if (!held_q) begin
            held_d = 1'b1;
            hold_d = data_sram_rdata;
        end
    end

    // Stage register and hold buffer, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '0;
            hold_q <= '0;
            held_q <= 1'b0;
        end else begin
            pipe_q <= pipe_d;
            hold_q <= hold_d;
            held_q <= held_d;
        end
    end

    assign rdata  = held_q ? hold_q : data_sram_rdata;
    assign lane_b = sel == 4'b0001 ? rdata[7:0]   :
                    sel == 4'b0010 ? rdata[15:8]  :
                    sel == 4'b0100 ? rdata[23:16] :
                    sel == 4'b1000 ? rdata[31:24] : 8'h0;
    assign ok_b   = sel == 4'b0001 || sel == 4'b0010 || sel == 4'b0100 || sel == 4'b1000;
    assign lane_h = sel == 4'b0011 ? rdata[15:0] : sel == 4'b1100 ? rdata[31:16] : 16'h0;
    assign ok_h   = sel == 4'b0011 || sel == 4'b1100;

    // Invalid lane patterns fall through to zero load data
    always_comb begin
        load_data = '0;
        if (lsu_op[0] && ok_b)
            load_data = {{24{lane_b[7]}}, lane_b};
        else if (lsu_op[1] && ok_b)
            load_data = {24'h0, lane_b};
        else if (lsu_op[2] && ok_h)
            load_data = {{16{lane_h[15]}}, lane_h};
        else if (lsu_op[3] && ok_h)
            load_data = {16'h0, lane_h};
        else if (lsu_op[4] && sel == 4'b1111)
            load_data = rdata;
    end

    assign result       = pipe_q[103] ? load_data : ex_result;
    assign mem12wb_bus  = {pipe_q[104:96], result, pipe_q[63:0]};
    assign mem12rf_bus  = {pipe_q[101:96], result};
    assign mem1_is_load = |lsu_op[4:0];
endmodule
